// File: rtl/mem_access.sv
// MEM stage bus controller: one SRAM-like transaction per instruction,
// load alignment/extension, and address-error reporting toward CP0.
module mem_access #(
  parameter int ADEL_BIT = 4,
  parameter int ADES_BIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        ex_mem_advance,
  input  logic        mem_mem_to_reg,
  input  logic        mem_ram_write_enable,
  input  logic [1:0]  mem_ls_width,
  input  logic        mem_ls_unsigned,
  input  logic [31:0] mem_ram_addr,
  input  logic [31:0] mem_ram_write_data,
  input  logic [31:0] mem_alu_data,
  input  logic [31:0] mem_exception_type_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        data_stall,
  output logic [31:0] mem_wb_data,
  output logic [31:0] mem_exception_type_o,
  output logic [31:0] mem_badvaddr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic        killed;
  logic [31:0] load_reg;

  logic        w_byte, w_half, w_word;
  logic        access, misalign, bad, go;
  logic        req_c, stall_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] wdata_c, load_c, exc_c;

  assign w_byte   = mem_ls_width == 2'd0;
  assign w_half   = mem_ls_width == 2'd1;
  assign w_word   = mem_ls_width[1];
  assign access   = mem_mem_to_reg | mem_ram_write_enable;
  assign misalign = (w_half & mem_ram_addr[0])
                  | (w_word & |mem_ram_addr[1:0]);
  assign bad      = access & misalign;
  assign go       = access & ~misalign
                  & ~|mem_exception_type_i & ~exception;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The bus cannot cancel, so a flushed access is drained, then dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      killed   <= 1'b0;
      load_reg <= 32'd0;
    end else begin
      if (state == RESP && data_data_ok)
        killed <= 1'b0;
      else if ((state == REQ || state == RESP) && exception)
        killed <= 1'b1;
      if (state == RESP && data_data_ok && !(killed | exception))
        load_reg <= load_c;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = data_addr_ok ? RESP : REQ;
      REQ:  if (data_addr_ok) state_nx = RESP;
      RESP: if (data_data_ok)
              state_nx = (killed | exception) ? IDLE : DONE;
      DONE: if (ex_mem_advance | exception) state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_c   = 1'b0;
    stall_c = 1'b0;
    unique case (state)
      IDLE: begin req_c = go;   stall_c = go;   end
      REQ:  begin req_c = 1'b1; stall_c = 1'b1; end
      RESP: stall_c = 1'b1;
      DONE: ;
    endcase
  end

  assign lane_b = data_rdata[{mem_ram_addr[1:0], 3'b000} +: 8];
  assign lane_h = mem_ram_addr[1] ? data_rdata[31:16]
                                  : data_rdata[15:0];

  always_comb begin
    wdata_c = mem_ram_write_data;
    load_c  = data_rdata;
    unique case (1'b1)
      w_byte: begin
        wdata_c = {4{mem_ram_write_data[7:0]}};
        load_c  = {{24{~mem_ls_unsigned & lane_b[7]}}, lane_b};
      end
      w_half: begin
        wdata_c = {2{mem_ram_write_data[15:0]}};
        load_c  = {{16{~mem_ls_unsigned & lane_h[15]}}, lane_h};
      end
      w_word: begin
        wdata_c = mem_ram_write_data;
        load_c  = data_rdata;
      end
    endcase
  end

  always_comb begin
    exc_c = mem_exception_type_i;
    if (bad & mem_mem_to_reg)
      exc_c[ADEL_BIT] = 1'b1;
    else if (bad)
      exc_c[ADES_BIT] = 1'b1;
  end

  assign data_req   = rst & req_c;
  assign data_stall = rst & stall_c;
  assign data_wr    = rst & mem_ram_write_enable;
  assign data_size  = {2{rst}} & (w_word ? 2'd2 : mem_ls_width);
  assign data_addr  = {32{rst}} & mem_ram_addr;
  assign data_wdata = {32{rst}} & wdata_c;

  assign mem_wb_data = {32{rst}} &
    ((state == DONE && mem_mem_to_reg) ? load_reg : mem_alu_data);
  assign mem_exception_type_o = {32{rst}} & exc_c;
  assign mem_badvaddr = {32{rst & bad}} & mem_ram_addr;

endmodule

// File: tb/tb_mem_access.sv
// Randomised scoreboard bench for mem_access with a latency-programmable
// bus responder and directed corner cases.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception, ex_mem_advance;
  logic        mem_mem_to_reg, mem_ram_write_enable;
  logic [1:0]  mem_ls_width;
  logic        mem_ls_unsigned;
  logic [31:0] mem_ram_addr, mem_ram_write_data;
  logic [31:0] mem_alu_data, mem_exception_type_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  logic        data_stall;
  logic [31:0] mem_wb_data, mem_exception_type_o, mem_badvaddr;

  mem_access #(.ADEL_BIT(4), .ADES_BIT(5)) dut (
    .clk(clk), .rst(rst),
    .exception(exception), .ex_mem_advance(ex_mem_advance),
    .mem_mem_to_reg(mem_mem_to_reg),
    .mem_ram_write_enable(mem_ram_write_enable),
    .mem_ls_width(mem_ls_width), .mem_ls_unsigned(mem_ls_unsigned),
    .mem_ram_addr(mem_ram_addr),
    .mem_ram_write_data(mem_ram_write_data),
    .mem_alu_data(mem_alu_data),
    .mem_exception_type_i(mem_exception_type_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .mem_wb_data(mem_wb_data),
    .mem_exception_type_o(mem_exception_type_o),
    .mem_badvaddr(mem_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] wb;
    logic [31:0] exc;
    logic [31:0] badv;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bus_t mb;
  res_t mr;
  int   nchecks = 0;
  int   nerr = 0;
  bit   active = 0;

  int          cur_aw = 0;
  int          cur_dw = 1;
  logic [31:0] cur_rdata = 32'd0;
  bit          outstanding = 0;
  int          wcnt = 0;
  int          dcnt = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchecks++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", n, a, e);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] rd,
      logic [31:0] a, logic [1:0] w, bit uns);
    logic [31:0] v;
    if (w == 2'd0) begin
      v = (rd >> ((a % 4) * 8)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = (rd >> (((a / 2) % 2) * 16)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(logic [31:0] wd,
      logic [1:0] w);
    if (w == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (w == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // Bus responder: accepts after cur_aw waiting cycles, answers cur_dw later
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      outstanding = 0;
      wcnt = 0;
      dcnt = 0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
    end else begin
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata = $urandom;
      if (outstanding) begin
        dcnt++;
        if (dcnt >= cur_dw) begin
          data_data_ok = 1'b1;
          data_rdata = cur_rdata;
          outstanding = 0;
        end
      end else if (data_req) begin
        if (wcnt >= cur_aw) begin
          data_addr_ok = 1'b1;
          outstanding = 1;
          wcnt = 0;
          dcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && data_req && data_addr_ok) begin
      if (bus_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_req: got request at %08h expected none",
                 data_addr);
      end else begin
        mb = bus_q.pop_front();
        chk("bus_addr", data_addr, mb.addr);
        chk("bus_wr", 32'(data_wr), 32'(mb.wr));
        chk("bus_size", 32'(data_size), 32'(mb.size));
        chk("bus_wdata", data_wdata, mb.wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && active && !data_stall) begin
      active = 0;
      if (res_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL result_q: got output with empty queue expected entry");
      end else begin
        mr = res_q.pop_front();
        chk("wb_data", mem_wb_data, mr.wb);
        chk("exc_o", mem_exception_type_o, mr.exc);
        chk("badvaddr", mem_badvaddr, mr.badv);
      end
    end
  end

  task automatic bubble();
    mem_mem_to_reg = 1'b0;
    mem_ram_write_enable = 1'b0;
    mem_ls_width = 2'd2;
    mem_ls_unsigned = 1'b0;
    mem_ram_addr = 32'd0;
    mem_ram_write_data = 32'd0;
    mem_alu_data = 32'd0;
    mem_exception_type_i = 32'd0;
    exception = 1'b0;
    ex_mem_advance = 1'b0;
  endtask

  task automatic run_inst(input bit ld, input bit st,
      input logic [1:0] w, input bit uns, input logic [31:0] a,
      input logic [31:0] wd, input logic [31:0] alu,
      input logic [31:0] exci, input logic [31:0] rd,
      input int aw, input int dw, input int kill_at, input int hold);
    bit          acc, mis, go_e;
    int          c, st_n, rq_n;
    logic [31:0] wb_e;
    bus_t        b;
    res_t        r;
    @(posedge clk);
    #1;
    mem_mem_to_reg = ld;
    mem_ram_write_enable = st;
    mem_ls_width = w;
    mem_ls_unsigned = uns;
    mem_ram_addr = a;
    mem_ram_write_data = wd;
    mem_alu_data = alu;
    mem_exception_type_i = exci;
    exception = 1'b0;
    ex_mem_advance = 1'b0;
    cur_aw = aw;
    cur_dw = dw;
    cur_rdata = rd;
    acc = ld || st;
    mis = acc && ((w == 2'd1 && a % 2 != 0) || (w >= 2'd2 && a % 4 != 0));
    go_e = acc && !mis && exci == 0;
    if (go_e) begin
      b.addr = a;
      b.wr = st;
      b.size = (w == 2'd3) ? 2'd2 : w;
      b.wdata = ref_wdata(wd, w);
      bus_q.push_back(b);
    end
    wb_e = (go_e && ld && kill_at == 0) ? ref_load(rd, a, w, uns) : alu;
    if (!(go_e && kill_at > 0)) begin
      r.wb = wb_e;
      r.exc = exci | ((mis && ld) ? 32'h10 : 32'h0)
                   | ((mis && !ld) ? 32'h20 : 32'h0);
      r.badv = mis ? a : 32'd0;
      res_q.push_back(r);
      active = 1;
    end
    c = 0;
    st_n = 0;
    rq_n = 0;
    forever begin
      @(negedge clk);
      if (data_stall) st_n++;
      if (data_req) rq_n++;
      if (!data_stall || c >= 60) break;
      @(posedge clk);
      #1;
      c++;
      exception = (kill_at > 0 && c == kill_at);
      if (exception) mem_exception_type_i = 32'h1;
    end
    if (c >= 60) begin
      nchecks++;
      nerr++;
      $display("FAIL stall_timeout: got stall after 60 cycles expected release");
    end
    chk("stall_cycles", st_n, go_e ? aw + dw + 1 : 0);
    chk("req_cycles", rq_n, go_e ? aw + 1 : 0);
    #1;
    if (active) begin
      active = 0;
      if (res_q.size() > 0) void'(res_q.pop_front());
      nchecks++;
      nerr++;
      $display("FAIL no_result: got no output expected one");
    end
    if (go_e && kill_at > 0) chk("killed_wb", mem_wb_data, alu);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_req", 32'(data_req), 32'd0);
      chk("hold_stall", 32'(data_stall), 32'd0);
      chk("hold_wb", mem_wb_data, wb_e);
    end
    @(posedge clk);
    #1;
    exception = 1'b0;
    ex_mem_advance = 1'b1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_req"}, 32'(data_req), 32'd0);
    chk({tag, "_stall"}, 32'(data_stall), 32'd0);
    chk({tag, "_wb"}, mem_wb_data, 32'd0);
    chk({tag, "_exc"}, mem_exception_type_o, 32'd0);
    chk({tag, "_badv"}, mem_badvaddr, 32'd0);
    chk({tag, "_addr"}, data_addr, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ld, st, uns;
    int          kind, aw, dw, kill, hold;
    logic [1:0]  w, low;
    logic [31:0] a, exci;

    rst = 1'b0;
    bubble();
    mem_mem_to_reg = 1'b1;
    mem_ram_addr = 32'h0000_1000;
    mem_alu_data = 32'h0000_0055;
    repeat (2) @(negedge clk);
    chk_reset("rst_lw");
    mem_ram_addr = 32'h0000_1002;
    mem_exception_type_i = 32'h8;
    #1;
    chk_reset("rst_mis");
    @(posedge clk);
    #1;
    bubble();
    @(negedge clk);
    rst = 1'b1;

    run_inst(1, 0, 2, 0, 32'h1000, 0, 32'h11, 0, 32'hDEAD_BEEF, 0, 1, 0, 0);
    run_inst(1, 0, 0, 0, 32'h1003, 0, 32'h12, 0, 32'h8012_3456, 0, 1, 0, 1);
    run_inst(1, 0, 0, 1, 32'h1003, 0, 32'h13, 0, 32'h8012_3456, 1, 1, 0, 0);
    run_inst(1, 0, 1, 0, 32'h1002, 0, 32'h14, 0, 32'h8001_1234, 0, 2, 0, 0);
    run_inst(0, 1, 0, 0, 32'h2001, 32'h1234_5678, 32'h15, 0, 0, 3, 1, 0, 0);
    run_inst(1, 0, 2, 0, 32'h3002, 0, 32'h16, 0, 0, 0, 1, 0, 1);
    run_inst(0, 1, 1, 0, 32'h3001, 32'hABCD, 32'h17, 0, 0, 0, 1, 0, 0);
    run_inst(1, 0, 2, 0, 32'h4000, 0, 32'h18, 0, 32'h0BAD_F00D, 0, 3, 1, 2);
    run_inst(1, 0, 2, 0, 32'h4004, 0, 32'h19, 0, 32'h1357_9BDF, 2, 1, 1, 0);
    run_inst(1, 0, 2, 0, 32'h4008, 0, 32'h1A, 0, 32'h2468_ACE0, 0, 1, 0, 0);
    run_inst(1, 0, 3, 0, 32'h400C, 0, 32'h1B, 0, 32'hCAFE_F00D, 1, 2, 0, 3);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom % 10;
      ld = kind < 5;
      st = kind >= 5 && kind < 8;
      uns = $urandom % 2;
      w = 2'($urandom % 4);
      low = 2'($urandom % 4);
      if ($urandom % 3 != 0) begin
        if (w == 2'd1) low[0] = 1'b0;
        else if (w >= 2'd2) low = 2'd0;
      end
      a = 32'h0001_0000 | ($urandom & 32'h0000_FFFC) | 32'(low);
      exci = ($urandom % 8 == 0) ? (32'h1 << ($urandom % 32)) : 32'h0;
      aw = $urandom % 4;
      dw = 1 + $urandom % 3;
      kill = ($urandom % 6 == 0) ? 1 + int'($urandom % (aw + dw)) : 0;
      hold = $urandom % 3;
      run_inst(ld, st, w, uns, a, $urandom, $urandom, exci, $urandom,
               aw, dw, kill, hold);
    end

    @(posedge clk);
    #1;
    bubble();
    mem_mem_to_reg = 1'b1;
    mem_ram_addr = 32'h0000_5000;
    mem_alu_data = 32'h0000_0077;
    cur_aw = 6;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    bus_q.delete();
    @(posedge clk);
    #1;
    bubble();
    @(negedge clk);
    rst = 1'b1;
    run_inst(1, 0, 2, 0, 32'h6000, 0, 32'h1C, 0, 32'h7654_3210, 0, 1, 0, 0);

    @(posedge clk);
    #1;
    bubble();
    repeat (3) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage controller sitting directly downstream of the EX/MEM pipeline register. It takes the held load/store fields from EX/MEM and issues at most one transaction per instruction on the SRAM-like data bus. It raises a data stall until the transaction completes, aligns and extends load data, and produces the write-back value. Misaligned addresses are reported as address-error exceptions toward CP0.

## Interface
Parameters:
- ADEL_BIT, 4, bit index in exception vector marking load/fetch address error
- ADES_BIT, 5, bit index in exception vector marking store address error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- exception  in  1  pipeline flush from CP0, combinational, same cycle
- ex_mem_advance  in  1  EX/MEM loads a new instruction at this edge
- mem_mem_to_reg  in  1  instruction is a load
- mem_ram_write_enable  in  1  instruction is a store
- mem_ls_width  in  2  0 byte, 1 half, 2 word; 3 is treated as word
- mem_ls_unsigned  in  1  zero-extend load (lbu/lhu)
- mem_ram_addr  in  32  effective address
- mem_ram_write_data  in  32  store source register, value in low bits
- mem_alu_data  in  32  non-load result
- mem_exception_type_i  in  32  exceptions already flagged upstream
- data_req  out  1  bus request
- data_wr  out  1  1 write, 0 read
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address, equals mem_ram_addr
- data_wdata  out  32  store data replicated across lanes
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  response/write-complete this cycle
- data_rdata  in  32  read data, valid with data_data_ok
- data_stall  out  1  freeze EX/MEM and earlier
- mem_wb_data  out  32  write-back value
- mem_exception_type_o  out  32  upstream vector OR address-error bits
- mem_badvaddr  out  32  faulting address, else 0

## Operation
- access = mem_mem_to_reg | mem_ram_write_enable.
- misalign = (width half & addr[0]) | (width word & addr[1:0]!=0).
- go = access & !misalign & mem_exception_type_i==0 & !exception.
- FSM states: IDLE, REQ, RESP, DONE; plus killed flag.
- IDLE: data_req = go. On go & addr_ok -> RESP; go & !addr_ok -> REQ.
- REQ: data_req=1, fields held from inputs. On addr_ok -> RESP.
- RESP: data_req=0. On data_ok: if killed -> IDLE and clear killed; else capture aligned data -> DONE.
- DONE: data_req=0. On ex_mem_advance or exception -> IDLE. A held instruction is never re-issued.
- killed is set when exception=1 in REQ or RESP. The request stays asserted until addr_ok because the bus has no cancel, then the response is drained and discarded.
- data_stall = (IDLE & go) | REQ | RESP.
- Store data: byte -> {4{wd[7:0]}}; half -> {2{wd[15:0]}}; word -> wd.
- Load alignment:
  - byte: lane = addr[1:0].
  - half: lane = addr[1] (upper half when 1).
  - Sign-extend unless mem_ls_unsigned.
- mem_wb_data = load_reg in DONE when the instruction is a load, else mem_alu_data.
- Misaligned access: no bus request, no stall. ADEL_BIT (load) or ADES_BIT (store) is set in mem_exception_type_o and mem_badvaddr = mem_ram_addr.

## Timing
- Reset (rst=0, async) returns:
  - state IDLE, killed 0, load_reg 0.
  - data_req 0, data_stall 0, mem_wb_data 0.
  - mem_exception_type_o 0, mem_badvaddr 0.
- During reset, all outputs are forced to 0 regardless of inputs.
- Best-case load: addr_ok in the issue cycle, data_ok the next cycle. data_stall is high 2 cycles, data is valid in DONE on cycle 3.
- Store completion also waits for data_ok; the write is not posted.
- data_addr, data_wr, data_size and data_wdata are combinational from inputs. They are stable because EX/MEM is frozen while data_stall=1.
- addr_ok and data_ok arriving in the same cycle while in REQ: take addr_ok only, and wait for data_ok in RESP.
- Reset mid-transaction: the FSM returns to IDLE. The bus is reset by the same rst.

## Test plan
- lw at 0x1000, addr_ok immediate, data_ok +1 with rdata 0xDEADBEEF -> stall for 2 cycles, then mem_wb_data=0xDEADBEEF in DONE; data_req pulses exactly once.
- lb at 0x1003 with rdata 0x80xxxxxx -> 0xFFFFFF80; lbu gives 0x00000080; lh at 0x1002 with rdata 0x8001xxxx -> 0xFFFF8001.
- sb at 0x2001 with wdata 0x12345678, addr_ok delayed 3 cycles -> data_req held 4 cycles, data_wdata=0x78787878, data_size=0, data_wr=1.
- lw at 0x3002 -> no data_req, data_stall 0, mem_exception_type_o bit4 set, mem_badvaddr=0x3002; sh at 0x3001 -> bit5 set.
- lw in RESP, exception pulse, data_ok 2 cycles later -> stall held until data_ok, state returns to IDLE, no DONE, next access issues normally.
- After DONE, ex_mem_advance held 0 for 3 cycles with the same instruction held on the inputs -> no second data_req.
